// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg: opcode constants, immediate format codes and width default
package imm_decode_stage_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   typedef enum logic [2:0] {
      FMT_I = 3'b000,
      FMT_S = 3'b001,
      FMT_B = 3'b010,
      FMT_J = 3'b011,
      FMT_U = 3'b100,
      FMT_Z = 3'b101
   } imm_src_e;
endpackage

// File: rtl/imm_decode_stage_format_gen.sv
// imm_format_gen: assembles and extends the immediate of one instruction for a given format
module imm_format_gen
   import imm_decode_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:0]     instr,
   input  imm_src_e        imm_src,
   output logic [XLEN-1:0] imm_ext
);
   logic signed [31:0] raw;
   // raw is already sign-extended to 32 bits; the signed cast carries that to XLEN
   always_comb begin
      raw = imm_src == FMT_I ? {{20{instr[31]}}, instr[31:20]}
          : imm_src == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
          : imm_src == FMT_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}
          : imm_src == FMT_J ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}
          : imm_src == FMT_U ? {instr[31:12], 12'b0}
          : imm_src == FMT_Z ? {27'b0, instr[19:15]}
          : '0;
      imm_ext = XLEN'(raw);
   end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: one-entry registered immediate decoder with valid/ready handshake
module imm_decode_stage
   import imm_decode_stage_pkg::*;
#(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter bit EN_ZICSR = 1'b0,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       imm_src,
   output logic [XLEN-1:0]  imm_ext,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);
   imm_src_e         dec_src, src_d, src_q;
   logic             dec_ill, take, keep;
   logic [XLEN-1:0]  gen_ext, ext_d, ext_q;
   logic             valid_d, valid_q, ill_d, ill_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   always_comb begin
      dec_src = FMT_I;
      dec_ill = 1'b0;
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_REG, OP_JALR: dec_src = FMT_I;
         OP_STORE:                         dec_src = FMT_S;
         OP_BRANCH:                        dec_src = FMT_B;
         OP_JAL:                           dec_src = FMT_J;
         OP_AUIPC, OP_LUI:                 dec_src = FMT_U;
         OP_SYSTEM:                        {dec_src, dec_ill} = EN_ZICSR ? {FMT_Z, 1'b0} : {FMT_I, 1'b1};
         default:                          dec_ill = 1'b1;
      endcase
      dec_ill = dec_ill || instr[1:0] != 2'b11;
      dec_src = dec_ill ? FMT_I : dec_src;
   end
   imm_format_gen #(.XLEN(XLEN)) u_gen (
      .instr   (instr),
      .imm_src (dec_src),
      .imm_ext (gen_ext)
   );
   assign in_ready = !valid_q || out_ready;
   assign take     = in_valid && in_ready && !flush;
   assign keep     = valid_q && !out_ready && !flush;
   // anything neither loaded nor held falls back to zero so no stale decode survives
   always_comb begin
      valid_d = take || keep;
      src_d   = take ? dec_src : keep ? src_q : FMT_I;
      ext_d   = take ? (dec_ill ? '0 : gen_ext) : keep ? ext_q : '0;
      ill_d   = take ? dec_ill : keep && ill_q;
      cnt_d   = take && dec_ill && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         src_q   <= FMT_I;
         ext_q   <= '0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         src_q   <= src_d;
         ext_q   <= ext_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
      end
   end
   assign out_valid   = valid_q;
   assign imm_src     = src_q;
   assign imm_ext     = ext_q;
   assign illegal     = ill_q;
   assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: vector table, corner sequences and random traffic against a reference model
module tb_imm_decode_stage;
   logic clk = 1'b0;
   logic reset, in_valid, flush, out_ready;
   logic [31:0] instr;
   logic rdy_a, rdy_b, ov_a, ov_b, ill_a, ill_b;
   logic [2:0] src_a, src_b;
   logic [31:0] ext_a;
   logic [63:0] ext_b;
   logic [1:0] cnt_a;
   logic [7:0] cnt_b;
   int passed = 0, total = 0;
   bit mv[2], mi[2];
   logic [2:0] ms[2];
   logic [63:0] me[2];
   int mc[2];
   always #5 clk = ~clk;
   imm_decode_stage #(.XLEN(32), .EN_ZICSR(1'b0), .CNT_W(2)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a), .instr(instr),
      .flush(flush), .out_valid(ov_a), .out_ready(out_ready), .imm_src(src_a),
      .imm_ext(ext_a), .illegal(ill_a), .illegal_cnt(cnt_a)
   );
   imm_decode_stage #(.XLEN(64), .EN_ZICSR(1'b1), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .instr(instr),
      .flush(flush), .out_valid(ov_b), .out_ready(out_ready), .imm_src(src_b),
      .imm_ext(ext_b), .illegal(ill_b), .illegal_cnt(cnt_b)
   );
   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src_a;
      logic [31:0] ext_a;
      bit          ill_a;
      logic [2:0]  src_b;
      logic [63:0] ext_b;
      bit          ill_b;
   } vec_t;
   vec_t tv[9];
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask
   function automatic longint sx(input longint f, input int n);
      return f >= (longint'(1) << (n - 1)) ? f - (longint'(1) << n) : f;
   endfunction
   // k=0 models the 32-bit no-CSR instance, k=1 the 64-bit CSR instance
   function automatic void ref_decode(input logic [31:0] i, input int k,
                                      output logic [2:0] s, output logic [63:0] e, output bit il);
      longint v;
      v = 0; s = 0; il = 0;
      case (i[6:0])
         7'h03, 7'h13, 7'h33, 7'h67: v = sx(longint'(i[31:20]), 12);
         7'h23: begin s = 1; v = sx(longint'({i[31:25], i[11:7]}), 12); end
         7'h63: begin s = 2; v = sx(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13); end
         7'h6F: begin s = 3; v = sx(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); end
         7'h17, 7'h37: begin s = 4; v = sx(longint'({i[31:12], 12'b0}), 32); end
         7'h73: if (k == 1) begin s = 5; v = longint'(i[19:15]); end else il = 1;
         default: il = 1;
      endcase
      if (i[1:0] != 2'b11) il = 1;
      if (il) begin s = 0; v = 0; end
      e = k == 1 ? v : v & 64'hFFFF_FFFF;
   endfunction
   task automatic model_edge();
      logic [2:0] s;
      logic [63:0] e;
      bit il, rdy;
      for (int k = 0; k < 2; k++) begin
         rdy = !mv[k] || out_ready;
         ref_decode(instr, k, s, e, il);
         if (reset) begin
            mv[k] = 0; ms[k] = 0; me[k] = 0; mi[k] = 0; mc[k] = 0;
         end else if (flush || (!(in_valid && rdy) && out_ready)) begin
            mv[k] = 0; ms[k] = 0; me[k] = 0; mi[k] = 0;
         end else if (in_valid && rdy) begin
            mv[k] = 1; ms[k] = s; me[k] = e; mi[k] = il;
            if (il && mc[k] < (k == 1 ? 255 : 3)) mc[k]++;
         end
      end
   endtask
   task automatic check_outs(input string t);
      chk({t, ".ov_a"}, ov_a, mv[0]);    chk({t, ".ov_b"}, ov_b, mv[1]);
      chk({t, ".src_a"}, src_a, ms[0]);  chk({t, ".src_b"}, src_b, ms[1]);
      chk({t, ".ext_a"}, ext_a, me[0]);  chk({t, ".ext_b"}, ext_b, me[1]);
      chk({t, ".ill_a"}, ill_a, mi[0]);  chk({t, ".ill_b"}, ill_b, mi[1]);
      chk({t, ".cnt_a"}, cnt_a, mc[0]);  chk({t, ".cnt_b"}, cnt_b, mc[1]);
   endtask
   task automatic cyc(input bit r, input bit v, input logic [31:0] ins, input bit f, input bit o,
                      input string t);
      reset = r; in_valid = v; instr = ins; flush = f; out_ready = o;
      #1;
      chk({t, ".rdy_a"}, rdy_a, !mv[0] || o);
      chk({t, ".rdy_b"}, rdy_b, !mv[1] || o);
      @(posedge clk);
      model_edge();
      #1;
      check_outs(t);
   endtask
   logic [6:0] ops[11] = '{7'h03, 7'h13, 7'h33, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h17, 7'h37, 7'h73, 7'h7F};
   initial begin
      tv[0] = '{32'hFFC12083, 3'd0, 32'hFFFFFFFC, 0, 3'd0, 64'hFFFFFFFFFFFFFFFC, 0};
      tv[1] = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 0, 3'd1, 64'hFFFFFFFFFFFFFFFC, 0};
      tv[2] = '{32'hFE000CE3, 3'd2, 32'hFFFFFFF8, 0, 3'd2, 64'hFFFFFFFFFFFFFFF8, 0};
      tv[3] = '{32'h123452B7, 3'd4, 32'h12345000, 0, 3'd4, 64'h0000000012345000, 0};
      tv[4] = '{32'h000FD073, 3'd0, 32'h00000000, 1, 3'd5, 64'h000000000000001F, 0};
      tv[5] = '{32'h8000006F, 3'd3, 32'hFFF00000, 0, 3'd3, 64'hFFFFFFFFFFF00000, 0};
      tv[6] = '{32'h7FF00013, 3'd0, 32'h000007FF, 0, 3'd0, 64'h00000000000007FF, 0};
      tv[7] = '{32'h0000007F, 3'd0, 32'h00000000, 1, 3'd0, 64'h0000000000000000, 1};
      tv[8] = '{32'h80000037, 3'd4, 32'h80000000, 0, 3'd4, 64'hFFFFFFFF80000000, 0};
      reset = 1; in_valid = 0; flush = 0; out_ready = 0; instr = 0;
      @(posedge clk);
      #1;
      cyc(1, 0, 0, 0, 0, "reset");
      for (int n = 0; n < 9; n++) begin
         cyc(0, 1, tv[n].instr, 0, 1, $sformatf("tbl%0d", n));
         chk($sformatf("tbl%0d.src_a", n), src_a, tv[n].src_a);
         chk($sformatf("tbl%0d.ext_a", n), ext_a, tv[n].ext_a);
         chk($sformatf("tbl%0d.ill_a", n), ill_a, tv[n].ill_a);
         chk($sformatf("tbl%0d.src_b", n), src_b, tv[n].src_b);
         chk($sformatf("tbl%0d.ext_b", n), ext_b, tv[n].ext_b);
         chk($sformatf("tbl%0d.ill_b", n), ill_b, tv[n].ill_b);
      end
      cyc(1, 0, 0, 0, 1, "bp_rst");
      cyc(0, 1, 32'h123452B7, 0, 1, "bp_load");
      for (int n = 0; n < 3; n++) begin
         cyc(0, 1, 32'hFFC12083, 0, 0, "bp_hold");
         chk("bp_hold.rdy", rdy_a, 0);
         chk("bp_hold.ext", ext_a, 32'h12345000);
      end
      cyc(0, 1, 32'hFFC12083, 0, 1, "bp_swap");
      chk("bp_swap.ov", ov_a, 1);
      chk("bp_swap.ext", ext_a, 32'hFFFFFFFC);
      cyc(0, 0, 0, 0, 1, "bp_drain");
      chk("bp_drain.ov", ov_a, 0);
      cyc(1, 0, 0, 0, 1, "sat_rst");
      for (int n = 0; n < 5; n++) begin
         cyc(0, 1, 32'h0000007F, 0, 1, "sat");
         chk("sat.cnt", cnt_a, n < 3 ? n + 1 : 3);
         chk("sat.ill", ill_a, 1);
         chk("sat.ext", ext_a, 0);
      end
      cyc(0, 1, 32'h0000007F, 1, 1, "flush");
      chk("flush.ov", ov_a, 0);
      chk("flush.cnt", cnt_a, 3);
      chk("flush.cnt_b", cnt_b, 5);
      cyc(0, 1, 32'h123452B7, 0, 1, "rm_load");
      cyc(0, 0, 0, 0, 0, "rm_hold");
      cyc(1, 1, 32'h0000007F, 0, 0, "rm_reset");
      chk("rm_reset.ov", ov_a, 0);
      chk("rm_reset.cnt", cnt_a, 0);
      chk("rm_reset.ext_b", ext_b, 0);
      cyc(0, 0, 0, 0, 0, "rm_after");
      for (int n = 0; n < 400; n++) begin
         logic [31:0] w;
         w = $urandom;
         if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 10)];
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, w,
             $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, "rand");
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
